sr_bank_arbiter: RTL

SR_BANK_ARBITER -- requirements
Module: sr_bank_arbiter

---
 rtl/sr_bank_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sr_bank_arbiter.sv
// ---------------------------------------------------------------------------
// sr_bank_arbiter
//
// A round-robin arbiter in front of a bank of SR-style flags. Several
// requesters share the bank. One operation completes every two cycles at
// most. In IDLE the arbiter picks a winner, starting the search at ptr, and
// latches that requester's (s, r, idx). In APPLY it pulses the grant and
// writes the flag. The written value shows on q at the edge that ends APPLY.
//
// Ports
//   clk      : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   req      : [NREQ]    per-requester request, held until its gnt bit is seen
//   s, r     : [NREQ]    per-requester set / reset bits, sampled with req
//   idx      : [NREQ*3]  per-requester flag index, requester i in [3i+2:3i]
//   err_clr  : clears the sticky error flag
//   gnt      : [NREQ]    one-hot, one-cycle grant pulse (registered)
//   q        : [NFLAG]   flag values (registered)
//   err      : sticky illegal-operation flag (S=R=1 or index out of range)
//   busy     : high while the FSM is in APPLY
// ---------------------------------------------------------------------------
module sr_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   s,
    input  logic [NREQ-1:0]   r,
    input  logic [NREQ*3-1:0] idx,
    input  logic              err_clr,
    output logic [NREQ-1:0]   gnt,
    output logic [NFLAG-1:0]  q,
    output logic              err,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [PW-1:0]    ptr_q,    ptr_d;
    logic [PW-1:0]    win_q,    win_d;
    logic             op_s_q,   op_s_d;
    logic             op_r_q,   op_r_d;
    logic [2:0]       op_idx_q, op_idx_d;
    logic [NREQ-1:0]  gnt_q,    gnt_d;
    logic [NFLAG-1:0] q_q,      q_d;
    logic             err_q,    err_d;
    logic             busy_q,   busy_d;

    logic             found_s;
    logic [PW-1:0]    win_s;
    logic             err_set_s;
    logic             bad_idx_s;

    // Round-robin search: the first asserted request at or above ptr wins,
    // wrapping from NREQ-1 back to 0.
    always_comb begin
        found_s = 1'b0;
        win_s   = {PW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req[(int'(ptr_q) + k) % NREQ]) begin
                found_s = 1'b1;
                win_s   = PW'((int'(ptr_q) + k) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic for the FSM, the latched operation and the flag bank.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        op_s_d    = op_s_q;
        op_r_d    = op_r_q;
        op_idx_d  = op_idx_q;
        gnt_d     = {NREQ{1'b0}};
        busy_d    = 1'b0;
        q_d       = q_q;
        err_set_s = 1'b0;
        bad_idx_s = (int'(op_idx_q) >= NFLAG);

        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d  = ST_APPLY;
                    win_d    = win_s;
                    op_s_d   = s[win_s];
                    op_r_d   = r[win_s];
                    op_idx_d = idx[int'(win_s) * 3 +: 3];
                    busy_d   = 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_d[i] = (PW'(i) == win_s);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                ptr_d   = (win_q == PW'(NREQ - 1)) ? {PW{1'b0}} : (win_q + PW'(1));
                if (bad_idx_s) begin
                    // Out-of-range index: request is still granted, but only
                    // the error flag is touched.
                    err_set_s = 1'b1;
                end else begin
                    case ({op_s_q, op_r_q})
                        2'b10: begin
                            for (int f = 0; f < NFLAG; f++) begin
                                if (int'(op_idx_q) == f) begin
                                    q_d[f] = 1'b1;
                                end else begin
                                    q_d[f] = q_q[f];
                                end
                            end
                        end
                        2'b01: begin
                            for (int f = 0; f < NFLAG; f++) begin
                                if (int'(op_idx_q) == f) begin
                                    q_d[f] = 1'b0;
                                end else begin
                                    q_d[f] = q_q[f];
                                end
                            end
                        end
                        2'b11: begin
                            err_set_s = 1'b1;
                        end
                        default: begin
                            q_d = q_q;
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new error outranks a coincident clear request.
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State, latched operation and registered outputs; reset aborts any
    // operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= {PW{1'b0}};
            win_q    <= {PW{1'b0}};
            op_s_q   <= 1'b0;
            op_r_q   <= 1'b0;
            op_idx_q <= 3'd0;
            gnt_q    <= {NREQ{1'b0}};
            q_q      <= {NFLAG{1'b0}};
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            op_s_q   <= op_s_d;
            op_r_q   <= op_r_d;
            op_idx_q <= op_idx_d;
            gnt_q    <= gnt_d;
            q_q      <= q_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign q    = q_q;
    assign err  = err_q;
    assign busy = busy_q;

endmodule
